burst_beat_sequencer: RTL and testbench
=======================================

# burst_beat_sequencer

Downstream stage for the 8-way priority request arbiter. Consumes the arbitrated `{id, offset}` request stream and buffers up to DEPTH requests. Expands each request into a wrap-around burst of BEATS beats that starts at `offset` (critical-beat-first). Each beat carries the requester id, the beat index and a last flag, for the refill/data-return path.

## Interface
- `BEATS`, 8: beats per burst; power of two, ≥2; beat index width `BW = log2(BEATS)` (3 at default).
- `IDW`, 3: requester id width.
- `DEPTH`, 2: request buffer entries; power of two, ≥1.

- `clock`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `io_in_valid`  in  1  arbitrated request valid.
- `io_in_ready`  out  1  buffer can accept a request.
- `io_in_bits_id`  in  IDW  requester id.
- `io_in_bits_offset`  in  BW  starting beat.
- `io_out_valid`  out  1  beat valid.
- `io_out_ready`  in  1  consumer accepts beat.
- `io_out_bits_id`  out  IDW  id of current burst.
- `io_out_bits_beat`  out  BW  beat index.
- `io_out_bits_last`  out  1  final beat of burst.
- `io_busy`  out  1  burst in progress or buffer non-empty.

## Operation
- Request buffer: DEPTH-entry circular FIFO of `{id, offset}` with wr/rd pointers and an occupancy count (`log2(DEPTH)+1` bits).
  - `io_in_ready = count != DEPTH`.
  - Enqueue on `io_in_valid & io_in_ready`.
  - The buffer has no bypass, so `io_in_ready` does not depend on `io_out_ready`.
- Sequencer FSM has two states:
  - **IDLE**: `io_out_valid = 0`.
  - **BURST**: registers `cur_id`, `start`, `beat` (BW bits) and `cnt` (BW bits, beats issued).
- Load (dequeue) happens when the FIFO is non-empty and either:
  - the FSM is in IDLE, or
  - the FSM is in BURST and the last beat fires this cycle.
- On load: `cur_id <= head.id`, `beat <= head.offset`, `cnt <= 0`, state goes to BURST.
- In BURST:
  - `io_out_valid = 1`, `io_out_bits_id = cur_id`, `io_out_bits_beat = beat`.
  - `io_out_bits_last = (cnt == BEATS-1)`.
- On a beat fire (`io_out_valid & io_out_ready`):
  - `beat <= beat + 1`, wrapping mod BEATS (natural BW-bit overflow).
  - `cnt <= cnt + 1`.
- Last beat fire with no load: go to IDLE. Last beat fire with a load: stay in BURST with the new request, giving zero bubble.
- Output stability: while `io_out_valid & !io_out_ready`, all `io_out_bits_*` hold.
- Simultaneous enqueue and dequeue with the FIFO full:
  - `io_in_ready` is 0 that cycle, so no enqueue occurs.
  - Count decrements; the new request is accepted next cycle.
- Simultaneous enqueue and dequeue with the FIFO not full: count is unchanged and both pointers advance.
- `io_busy = (state == BURST) | (count != 0)`.

## Timing
- Reset (async assert, sync-safe deassert by the system):
  - state IDLE; pointers, count, `beat`, `cnt` and `cur_id` all 0.
  - Outputs: `io_out_valid = 0`, `io_in_ready = 1`, `io_busy = 0`, `io_out_bits_* = 0`, `io_out_bits_last = 0`.
- Reset mid-burst: the burst and all buffered requests are discarded; no partial beat survives.
- Latency: request accepted at edge k → FIFO head visible in cycle k+1 → loaded at edge k+1 → first beat valid in cycle k+2.
- Throughput: one beat per cycle with `io_out_ready` held high. Back-to-back bursts are gapless when the next request is buffered before the last beat fires.
- All outputs are driven from registers, or from count/state compares only. There is no combinational path from `io_in_*` to `io_out_*`, nor from `io_out_ready` to `io_in_ready`.

## Structure
- Shared package `beat_seq_pkg`:
  - `req_t` struct `{id, offset}`.
  - FSM state enum `{S_IDLE, S_BURST}`.
  - Default constants `BEATS_DEF = 8`, `IDW_DEF = 3`.
- One sub-module, `req_fifo`: the parameterised DEPTH×`req_t` circular buffer with enq/deq handshakes and a count output.
- Top level: FSM, beat and count counters, and output assignment.

## Test plan
- **Single request:** after reset, send id=5, offset=6 with `io_out_ready = 1`.
  - First beat appears 2 cycles after acceptance.
  - Beats 6,7,0,1,2,3,4,5, all id 5; last=1 only on beat 5.
  - Then `io_out_valid = 0` and `io_busy = 0`.
- **Back-to-back:** enqueue id=1/offset=0, then id=2/offset=3 on consecutive cycles.
  - 16 consecutive beats with no gap.
  - Second burst runs 3..7,0..2 with id 2.
- **Backpressure:** mid-burst on beat 2 of id=4/offset=0, hold `io_out_ready = 0` for 5 cycles.
  - Outputs are stable at id 4, beat 2, last 0.
  - Resumes at beat 3 after release.
- **Full buffer:** with DEPTH=2, hold `io_out_ready = 0` and offer 4 requests.
  - First loads into the sequencer; next two fill the FIFO.
  - `io_in_ready = 0` while the FIFO holds 2.
  - Fourth is accepted only after the first burst's last beat fires.
- **Reset mid-operation:** assert `reset` low during beat 3 of a burst with 1 request buffered.
  - Outputs go to reset values immediately (asynchronously).
  - After release, no stale beats; a new request id=7/offset=1 produces a clean burst 1..7,0.
- **Wrap edge:** offset=7 yields beats 7,0..6 with last on beat 6. offset=0 yields 0..7 with last on beat 7.

Source files
------------

// File: rtl/beat_seq_pkg.sv
// Shared types for the burst beat sequencer:
// request bundle, FSM states, default sizes.
package beat_seq_pkg;

  localparam int BEATS_DEF = 8;
  localparam int IDW_DEF   = 3;
  localparam int BW_DEF    = $clog2(BEATS_DEF);

  typedef struct packed {
    logic [IDW_DEF-1:0] id;
    logic [BW_DEF-1:0]  offset;
  } req_t;

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

endpackage

// File: rtl/req_fifo.sv
// Circular request buffer with enq/deq handshakes.
// Ready depends only on occupancy, never on the dequeue side.
module req_fifo
  import beat_seq_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = req_t,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_enq_valid,
  output logic          o_enq_ready,
  input  T              i_enq_data,
  output logic          o_deq_valid,
  input  logic          i_deq_ready,
  output T              o_deq_data,
  output logic [CW-1:0] o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_enq;
  logic          w_deq;

  assign o_enq_ready = (r_count != CW'(DEPTH));
  assign o_deq_valid = (r_count != '0);
  assign o_deq_data  = r_mem[r_rd_ptr];
  assign o_count     = r_count;
  assign w_enq       = i_enq_valid & o_enq_ready;
  assign w_deq       = i_deq_ready & o_deq_valid;

  always_ff @(posedge clock) begin
    if (w_enq) r_mem[r_wr_ptr] <= i_enq_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq)
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      if (w_deq)
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/burst_beat_sequencer.sv
// Expands buffered {id, offset} requests into wrap-around
// critical-beat-first bursts of BEATS beats.
module burst_beat_sequencer
  import beat_seq_pkg::*;
#(
  parameter int  BEATS = BEATS_DEF,
  parameter int  IDW   = IDW_DEF,
  parameter int  DEPTH = 2,
  localparam int BW    = $clog2(BEATS)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           io_in_valid,
  output logic           io_in_ready,
  input  logic [IDW-1:0] io_in_bits_id,
  input  logic [BW-1:0]  io_in_bits_offset,
  output logic           io_out_valid,
  input  logic           io_out_ready,
  output logic [IDW-1:0] io_out_bits_id,
  output logic [BW-1:0]  io_out_bits_beat,
  output logic           io_out_bits_last,
  output logic           io_busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [BW-1:0] LAST_CNT = BW'(BEATS - 1);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [BW-1:0]  offset;
  } beat_req_t;

  state_t          r_state;
  state_t          w_next;
  logic [IDW-1:0]  r_cur_id;
  logic [BW-1:0]   r_beat;
  logic [BW-1:0]   r_cnt;
  beat_req_t       w_in;
  beat_req_t       w_head;
  logic            w_head_valid;
  logic [CW-1:0]   w_count;
  logic            w_fire;
  logic            w_last;
  logic            w_load;

  assign w_in = '{id: io_in_bits_id, offset: io_in_bits_offset};

  req_fifo #(
    .DEPTH (DEPTH),
    .T     (beat_req_t)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_enq_valid (io_in_valid),
    .o_enq_ready (io_in_ready),
    .i_enq_data  (w_in),
    .o_deq_valid (w_head_valid),
    .i_deq_ready (w_load),
    .o_deq_data  (w_head),
    .o_count     (w_count)
  );

  assign w_last = (r_cnt == LAST_CNT);
  assign w_fire = io_out_valid & io_out_ready;
  // Reload on the last beat keeps back-to-back bursts gapless.
  assign w_load = w_head_valid &
                  ((r_state == S_IDLE) | (w_fire & w_last));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_load) w_next = S_BURST;
      S_BURST: if (w_fire & w_last)
                 w_next = w_load ? S_BURST : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cur_id <= '0;
      r_beat   <= '0;
      r_cnt    <= '0;
    end else if (w_load) begin
      r_cur_id <= w_head.id;
      r_beat   <= w_head.offset;
      r_cnt    <= '0;
    end else if (w_fire) begin
      r_beat   <= r_beat + 1'b1;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    io_out_valid     = (r_state == S_BURST);
    io_out_bits_id   = r_cur_id;
    io_out_bits_beat = r_beat;
    io_out_bits_last = (r_state == S_BURST) & w_last;
    io_busy          = (r_state == S_BURST) | (w_count != '0);
  end

endmodule

// File: tb/tb_burst_beat_sequencer.sv
// Directed bench for burst_beat_sequencer: single, back-to-back,
// backpressure, full buffer, async reset and wrap bursts.
module tb_burst_beat_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       io_in_valid;
  logic       io_in_ready;
  logic [2:0] io_in_bits_id;
  logic [2:0] io_in_bits_offset;
  logic       io_out_valid;
  logic       io_out_ready;
  logic [2:0] io_out_bits_id;
  logic [2:0] io_out_bits_beat;
  logic       io_out_bits_last;
  logic       io_busy;

  int n_chk  = 0;
  int n_pass = 0;

  burst_beat_sequencer dut (
    .clock             (clock),
    .reset             (reset),
    .io_in_valid       (io_in_valid),
    .io_in_ready       (io_in_ready),
    .io_in_bits_id     (io_in_bits_id),
    .io_in_bits_offset (io_in_bits_offset),
    .io_out_valid      (io_out_valid),
    .io_out_ready      (io_out_ready),
    .io_out_bits_id    (io_out_bits_id),
    .io_out_bits_beat  (io_out_bits_beat),
    .io_out_bits_last  (io_out_bits_last),
    .io_busy           (io_busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic send(input logic [2:0] id, input logic [2:0] off);
    int t;
    io_in_valid       = 1'b1;
    io_in_bits_id     = id;
    io_in_bits_offset = off;
    t = 0;
    while (!io_in_ready && t < 50) begin
      step();
      t++;
    end
    chk("send_rdy", {31'd0, io_in_ready}, 32'd1);
    step();
    io_in_valid = 1'b0;
  endtask

  task automatic burst_chk(input logic [2:0] id, input logic [2:0] off);
    logic [2:0] b;
    for (int i = 0; i < 8; i++) begin
      b = off + 3'(i);
      chk("b_valid", {31'd0, io_out_valid}, 32'd1);
      chk("b_id", {29'd0, io_out_bits_id}, {29'd0, id});
      chk("b_beat", {29'd0, io_out_bits_beat}, {29'd0, b});
      chk("b_last", {31'd0, io_out_bits_last}, (i == 7) ? 32'd1 : 32'd0);
      step();
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_valid"}, {31'd0, io_out_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, io_busy}, 32'd0);
  endtask

  initial begin
    reset             = 1'b0;
    io_in_valid       = 1'b0;
    io_in_bits_id     = '0;
    io_in_bits_offset = '0;
    io_out_ready      = 1'b1;
    #3;
    chk("rst_valid", {31'd0, io_out_valid}, 32'd0);
    chk("rst_ready", {31'd0, io_in_ready}, 32'd1);
    chk("rst_busy", {31'd0, io_busy}, 32'd0);
    chk("rst_id", {29'd0, io_out_bits_id}, 32'd0);
    chk("rst_beat", {29'd0, io_out_bits_beat}, 32'd0);
    chk("rst_last", {31'd0, io_out_bits_last}, 32'd0);
    step();
    step();
    reset = 1'b1;
    step();

    // single request, 2-cycle latency
    send(3'd5, 3'd6);
    chk("lat_gap", {31'd0, io_out_valid}, 32'd0);
    chk("lat_busy", {31'd0, io_busy}, 32'd1);
    step();
    burst_chk(3'd5, 3'd6);
    idle_chk("single");

    // back-to-back, gapless
    io_in_valid       = 1'b1;
    io_in_bits_id     = 3'd1;
    io_in_bits_offset = 3'd0;
    step();
    io_in_bits_id     = 3'd2;
    io_in_bits_offset = 3'd3;
    step();
    io_in_valid = 1'b0;
    burst_chk(3'd1, 3'd0);
    burst_chk(3'd2, 3'd3);
    idle_chk("b2b");

    // backpressure on beat 2
    send(3'd4, 3'd0);
    step();
    step();
    step();
    io_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, io_out_valid}, 32'd1);
      chk("bp_id", {29'd0, io_out_bits_id}, 32'd4);
      chk("bp_beat", {29'd0, io_out_bits_beat}, 32'd2);
      chk("bp_last", {31'd0, io_out_bits_last}, 32'd0);
      step();
    end
    io_out_ready = 1'b1;
    chk("bp_hold", {29'd0, io_out_bits_beat}, 32'd2);
    step();
    for (int i = 3; i < 8; i++) begin
      chk("bp_beat_r", {29'd0, io_out_bits_beat}, i);
      chk("bp_last_r", {31'd0, io_out_bits_last}, (i == 7) ? 32'd1 : 32'd0);
      step();
    end
    idle_chk("bp");

    // full buffer
    io_out_ready      = 1'b0;
    io_in_valid       = 1'b1;
    io_in_bits_offset = 3'd0;
    io_in_bits_id     = 3'd1;
    chk("full_r0", {31'd0, io_in_ready}, 32'd1);
    step();
    io_in_bits_id = 3'd2;
    chk("full_r1", {31'd0, io_in_ready}, 32'd1);
    step();
    io_in_bits_id = 3'd3;
    chk("full_r2", {31'd0, io_in_ready}, 32'd1);
    step();
    io_in_bits_id = 3'd4;
    for (int i = 0; i < 3; i++) begin
      chk("full_nrdy", {31'd0, io_in_ready}, 32'd0);
      chk("full_id", {29'd0, io_out_bits_id}, 32'd1);
      chk("full_beat", {29'd0, io_out_bits_beat}, 32'd0);
      step();
    end
    io_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("full_drain_nrdy", {31'd0, io_in_ready}, 32'd0);
      chk("full_drain_beat", {29'd0, io_out_bits_beat}, i);
      step();
    end
    chk("full_rdy_after", {31'd0, io_in_ready}, 32'd1);
    chk("full_next_id", {29'd0, io_out_bits_id}, 32'd2);
    chk("full_next_beat", {29'd0, io_out_bits_beat}, 32'd0);
    io_out_ready = 1'b0;
    step();
    chk("full_again", {31'd0, io_in_ready}, 32'd0);
    io_in_valid  = 1'b0;
    io_out_ready = 1'b1;
    burst_chk(3'd2, 3'd0);
    burst_chk(3'd3, 3'd0);
    burst_chk(3'd4, 3'd0);
    idle_chk("full");

    // async reset during beat 3 with one request buffered
    io_in_valid       = 1'b1;
    io_in_bits_id     = 3'd6;
    io_in_bits_offset = 3'd0;
    step();
    io_in_bits_id     = 3'd3;
    io_in_bits_offset = 3'd2;
    step();
    io_in_valid = 1'b0;
    step();
    step();
    step();
    chk("pre_rst_beat", {29'd0, io_out_bits_beat}, 32'd3);
    chk("pre_rst_busy", {31'd0, io_busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", {31'd0, io_out_valid}, 32'd0);
    chk("arst_busy", {31'd0, io_busy}, 32'd0);
    chk("arst_ready", {31'd0, io_in_ready}, 32'd1);
    chk("arst_id", {29'd0, io_out_bits_id}, 32'd0);
    chk("arst_beat", {29'd0, io_out_bits_beat}, 32'd0);
    chk("arst_last", {31'd0, io_out_bits_last}, 32'd0);
    step();
    reset = 1'b1;
    step();
    idle_chk("post_rst0");
    step();
    idle_chk("post_rst1");
    send(3'd7, 3'd1);
    step();
    burst_chk(3'd7, 3'd1);
    idle_chk("rst_burst");

    // wrap edges
    send(3'd2, 3'd7);
    step();
    burst_chk(3'd2, 3'd7);
    send(3'd3, 3'd0);
    step();
    burst_chk(3'd3, 3'd0);
    idle_chk("wrap");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
